cfg_vpd_loader: RTL and testbench

- Fetches card-specific read-only config values from an external VPD word memory after reset, replacing fixed tie-offs.
- Validates magic and checksum, then atomically drives the subsystem ID, subsystem vendor ID and device serial number into cfg_func0 and cfg_func1.
- Holds defaults until a valid image commits.
- load_done lets config logic hold off responses until values are final.

---
 rtl/cfg_vpd_loader.sv | 161 ++++++++++++++++
 tb/tb_cfg_vpd_loader.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_vpd_loader.sv
// Loads subsystem ID/VID and device serial number from VPD memory after reset.
// Values commit atomically to both config functions only when magic and checksum pass.
module cfg_vpd_loader #(
  parameter int              ADDR_W         = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int              TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]     MAGIC          = 32'h4F43_5644,
  parameter logic [15:0]     DEF_SUBSYS_ID  = 16'h066A,
  parameter logic [15:0]     DEF_SUBSYS_VID = 16'h1014,
  parameter logic [63:0]     DEF_DSN        = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              reload,
  output logic              vpd_rd_req,
  output logic [ADDR_W-1:0] vpd_rd_addr,
  input  logic              vpd_rd_ack,
  input  logic [31:0]       vpd_rd_data,
  output logic [15:0]       f0_ro_csh_subsystem_id,
  output logic [15:0]       f0_ro_csh_subsystem_vendor_id,
  output logic [63:0]       f0_ro_dsn_serial_number,
  output logic [15:0]       f1_ro_csh_subsystem_id,
  output logic [15:0]       f1_ro_csh_subsystem_vendor_id,
  output logic              load_done,
  output logic [1:0]        load_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] vid;
    logic [63:0] dsn;
  } cfg_t;

  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              done_nxt;
  logic [1:0]        err_nxt;
  logic              cap, commit;
  logic [4:0][31:0]  stage;
  logic [31:0]       sum;
  cfg_t              cfg_q;

  assign sum = stage[0] + stage[1] + stage[2] + stage[3] + stage[4];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tcnt_nxt  = tcnt;
    req_nxt   = vpd_rd_req;
    addr_nxt  = vpd_rd_addr;
    done_nxt  = load_done;
    err_nxt   = load_error;
    cap       = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        idx_nxt   = '0;
        tcnt_nxt  = '0;
        req_nxt   = 1'b1;
        addr_nxt  = BASE_ADDR;
      end
      FETCH: begin
        if (vpd_rd_req && vpd_rd_ack) begin
          cap      = 1'b1;
          tcnt_nxt = '0;
          if (idx == 3'd0 && vpd_rd_data != MAGIC) begin
            // bad magic: abandon early, nothing else is worth reading
            req_nxt   = 1'b0;
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = 2'b01;
          end else if (idx == 3'd4) begin
            req_nxt   = 1'b0;
            state_nxt = CHECK;
          end else begin
            idx_nxt  = idx + 3'd1;
            addr_nxt = BASE_ADDR + ADDR_W'(idx) + ADDR_W'(1);
          end
        end else if (tcnt == TMAX) begin
          req_nxt   = 1'b0;
          state_nxt = DONE;
          done_nxt  = 1'b1;
          err_nxt   = 2'b11;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      CHECK: begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
        if (sum == 32'd0) begin
          commit  = 1'b1;
          err_nxt = 2'b00;
        end else begin
          err_nxt = 2'b10;
        end
      end
      DONE: begin
        if (reload) begin
          state_nxt = FETCH;
          idx_nxt   = '0;
          tcnt_nxt  = '0;
          req_nxt   = 1'b1;
          addr_nxt  = BASE_ADDR;
          done_nxt  = 1'b0;
          err_nxt   = 2'b00;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      tcnt        <= '0;
      vpd_rd_req  <= 1'b0;
      vpd_rd_addr <= BASE_ADDR;
      load_done   <= 1'b0;
      load_error  <= 2'b00;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      tcnt        <= tcnt_nxt;
      vpd_rd_req  <= req_nxt;
      vpd_rd_addr <= addr_nxt;
      load_done   <= done_nxt;
      load_error  <= err_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stage <= '0;
    else if (cap) stage[idx] <= vpd_rd_data;
  end

  // single register feeds both functions so f0/f1 can never disagree
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cfg_q <= '{id: DEF_SUBSYS_ID, vid: DEF_SUBSYS_VID, dsn: DEF_DSN};
    else if (commit)
      cfg_q <= '{id: stage[1][31:16], vid: stage[1][15:0], dsn: {stage[2], stage[3]}};
  end

  assign f0_ro_csh_subsystem_id        = cfg_q.id;
  assign f0_ro_csh_subsystem_vendor_id = cfg_q.vid;
  assign f0_ro_dsn_serial_number       = cfg_q.dsn;
  assign f1_ro_csh_subsystem_id        = cfg_q.id;
  assign f1_ro_csh_subsystem_vendor_id = cfg_q.vid;

endmodule

// File: tb/tb_cfg_vpd_loader.sv
// Bench for cfg_vpd_loader: VPD memory responder with per-word ack delays,
// handshake monitor, and an image-level reference model.
module tb_cfg_vpd_loader;
  localparam int          TO    = 16;
  localparam logic [31:0] MAGIC = 32'h4F43_5644;
  localparam logic [15:0] DID   = 16'h066A;
  localparam logic [15:0] DVID  = 16'h1014;
  localparam logic [63:0] DDSN  = 64'hDEAD_DEAD_DEAD_DEAD;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        reload = 1'b0;
  logic        vpd_rd_req;
  logic [7:0]  vpd_rd_addr;
  logic        vpd_rd_ack = 1'b0;
  logic [31:0] vpd_rd_data = '0;
  logic [15:0] f0_id, f0_vid, f1_id, f1_vid;
  logic [63:0] f0_dsn;
  logic        load_done;
  logic [1:0]  load_error;
  logic [127:0] outs;

  int errors = 0;
  int checks = 0;

  cfg_vpd_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .reload(reload),
    .vpd_rd_req(vpd_rd_req), .vpd_rd_addr(vpd_rd_addr),
    .vpd_rd_ack(vpd_rd_ack), .vpd_rd_data(vpd_rd_data),
    .f0_ro_csh_subsystem_id(f0_id), .f0_ro_csh_subsystem_vendor_id(f0_vid),
    .f0_ro_dsn_serial_number(f0_dsn),
    .f1_ro_csh_subsystem_id(f1_id), .f1_ro_csh_subsystem_vendor_id(f1_vid),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;
  assign outs = {f0_id, f0_vid, f0_dsn, f1_id, f1_vid};

  // VPD memory contents and per-word ack delay seen by the responder
  logic [31:0] img [5];
  int          dly [5];
  logic        force_ack = 1'b0;
  logic [31:0] force_data = '0;

  logic       active = 1'b0;
  logic [7:0] cur_addr = '0;
  int         wcnt = 0;
  int         widx;

  always @(negedge clock) begin
    if (force_ack) begin
      vpd_rd_ack  = 1'b1;
      vpd_rd_data = force_data;
    end else if (!vpd_rd_req) begin
      vpd_rd_ack = 1'b0;
      active     = 1'b0;
    end else begin
      if (!active || vpd_rd_addr != cur_addr) begin
        active   = 1'b1;
        cur_addr = vpd_rd_addr;
        wcnt     = 0;
      end
      widx = int'(vpd_rd_addr);
      if (widx < 5 && wcnt >= dly[widx]) begin
        vpd_rd_ack  = 1'b1;
        vpd_rd_data = img[widx];
      end else begin
        vpd_rd_ack  = 1'b0;
        vpd_rd_data = $urandom;
      end
      wcnt++;
    end
  end

  // handshake log plus address-stability watch while a request waits
  int         hs_cnt = 0;
  int         unstable = 0;
  logic [7:0] hs_addr [$];
  logic       prev_req = 1'b0, prev_hs = 1'b0;
  logic [7:0] prev_addr = '0;

  always @(posedge clock) begin
    if (!reset_n) begin
      prev_req = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (prev_req && !prev_hs && vpd_rd_req && vpd_rd_addr !== prev_addr) unstable++;
      prev_hs = vpd_rd_req && vpd_rd_ack;
      if (prev_hs) begin
        hs_cnt++;
        hs_addr.push_back(vpd_rd_addr);
      end
      prev_req  = vpd_rd_req;
      prev_addr = vpd_rd_addr;
    end
  end

  typedef struct {
    logic [1:0]  err;
    logic [15:0] id;
    logic [15:0] vid;
    logic [63:0] dsn;
    int          nreads;
  } exp_t;

  // outcome of loading the current image, given what was committed before
  function automatic exp_t model(input exp_t prev);
    exp_t e;
    logic [31:0] s;
    e = prev;
    s = img[0] + img[1] + img[2] + img[3] + img[4];
    if (img[0] !== MAGIC) begin
      e.err = 2'b01; e.nreads = 1;
    end else begin
      e.nreads = 5;
      if (s == 32'd0) begin
        e.err = 2'b00;
        e.id  = img[1][31:16];
        e.vid = img[1][15:0];
        e.dsn = {img[2], img[3]};
      end else begin
        e.err = 2'b10;
      end
    end
    return e;
  endfunction

  function automatic int exp_cycles(input exp_t e);
    int c;
    if (e.nreads == 1) return 1 + dly[0];
    c = 6;
    for (int i = 0; i < 5; i++) c += dly[i];
    return c;
  endfunction

  task automatic make_valid(input logic [15:0] id, input logic [15:0] vid, input logic [63:0] dsn);
    logic [31:0] s;
    img[0] = MAGIC;
    img[1] = {id, vid};
    img[2] = dsn[63:32];
    img[3] = dsn[31:0];
    s = img[0] + img[1] + img[2] + img[3];
    img[4] = 32'd0 - s;
  endtask

  task automatic set_dly(input int lo, input int hi);
    for (int i = 0; i < 5; i++) dly[i] = $urandom_range(hi, lo);
  endtask

  task automatic reset_and_release();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
  endtask

  // waits for load_done; counts edges and any output change before it
  task automatic run_load(input int reload_at, output int cyc, output int changed);
    logic [127:0] snap;
    snap = outs;
    cyc = 0;
    changed = 0;
    while (cyc < 2000) begin
      @(posedge clock);
      #1;
      cyc++;
      reload = (cyc == reload_at);
      if (load_done) break;
      if (outs !== snap) changed++;
    end
    reload = 1'b0;
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL load_timeout load_done=%b after %0d cycles, required 1", load_done, cyc);
    end
  endtask

  exp_t dflt, cur;

  task automatic test_reset();
    make_valid(16'h066B, 16'h1014, 64'h1234_5678_9ABC_DEF0);
    set_dly(0, 0);
    #2 reset_n = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({vpd_rd_req, vpd_rd_addr} !== 9'h000) begin
      errors++; $display("FAIL reset_req_addr got=%h required=000", {vpd_rd_req, vpd_rd_addr});
    end
    checks++;
    if (outs !== {DID, DVID, DDSN, DID, DVID}) begin
      errors++; $display("FAIL reset_outputs got=%h required=%h", outs, {DID, DVID, DDSN, DID, DVID});
    end
    checks++;
    if ({load_done, load_error} !== 3'b000) begin
      errors++; $display("FAIL reset_status got=%b required=000", {load_done, load_error});
    end
  endtask

  task automatic test_valid();
    int hs0, cyc, ch, bad;
    exp_t e;
    make_valid(16'h066B, 16'h1014, 64'h1234_5678_9ABC_DEF0);
    set_dly(0, 0);
    e = model(dflt);
    hs0 = hs_cnt;
    reset_and_release();
    run_load(-1, cyc, ch);
    checks++;
    if (cyc != 7) begin errors++; $display("FAIL valid_latency got=%0d required=7", cyc); end
    checks++;
    if (load_error !== 2'b00) begin errors++; $display("FAIL valid_error got=%b required=00", load_error); end
    checks++;
    if (outs !== {16'h066B, 16'h1014, 64'h1234_5678_9ABC_DEF0, 16'h066B, 16'h1014}) begin
      errors++; $display("FAIL valid_outputs got=%h required=%h", outs,
                         {16'h066B, 16'h1014, 64'h1234_5678_9ABC_DEF0, 16'h066B, 16'h1014});
    end
    bad = 0;
    for (int i = 0; i < 5; i++) if (hs_addr[hs0 + i] !== 8'(i)) bad++;
    checks++;
    if (hs_cnt - hs0 != e.nreads || bad != 0) begin
      errors++; $display("FAIL valid_reads got=%0d bad_addr=%0d required=%0d/0", hs_cnt - hs0, bad, e.nreads);
    end
    cur = e;
  endtask

  task automatic test_bad_magic();
    int hs0, cyc, ch;
    exp_t e;
    make_valid(16'h066B, 16'h1014, 64'h1234_5678_9ABC_DEF0);
    img[0] = 32'h0000_0000;
    set_dly(0, 0);
    e = model(dflt);
    hs0 = hs_cnt;
    reset_and_release();
    run_load(-1, cyc, ch);
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (load_error !== e.err || cyc != 2) begin
      errors++; $display("FAIL magic_error got=%b/%0dcyc required=%b/2cyc", load_error, cyc, e.err);
    end
    checks++;
    if (hs_cnt - hs0 != 1 || vpd_rd_req !== 1'b0) begin
      errors++; $display("FAIL magic_reads got=%0d req=%b required=1 req=0", hs_cnt - hs0, vpd_rd_req);
    end
    checks++;
    if (outs !== {e.id, e.vid, e.dsn, e.id, e.vid}) begin
      errors++; $display("FAIL magic_outputs got=%h required=%h", outs, {e.id, e.vid, e.dsn, e.id, e.vid});
    end
    cur = e;
  endtask

  task automatic test_bad_checksum();
    int hs0, cyc, ch;
    exp_t e;
    make_valid(16'h066B, 16'h1014, 64'h1234_5678_9ABC_DEF0);
    img[4] = img[4] + 32'd1;
    set_dly(0, 2);
    e = model(dflt);
    hs0 = hs_cnt;
    reset_and_release();
    run_load(-1, cyc, ch);
    checks++;
    if (load_error !== 2'b10 || cyc != exp_cycles(e) + 1) begin
      errors++; $display("FAIL csum_error got=%b/%0dcyc required=10/%0dcyc", load_error, cyc, exp_cycles(e) + 1);
    end
    checks++;
    if (hs_cnt - hs0 != 5 || outs !== {DID, DVID, DDSN, DID, DVID}) begin
      errors++; $display("FAIL csum_reads_outputs got=%0d/%h required=5/%h", hs_cnt - hs0, outs,
                         {DID, DVID, DDSN, DID, DVID});
    end
    cur = e;
  endtask

  task automatic test_timeout();
    int hs0, n;
    make_valid(16'h1111, 16'h2222, 64'h3333_4444_5555_6666);
    set_dly(0, 0);
    dly[2] = 100000;
    hs0 = hs_cnt;
    reset_and_release();
    for (int k = 0; k < 50; k++) begin
      @(posedge clock);
      #1;
      if (hs_cnt == hs0 + 2) break;
    end
    n = 0;
    while (n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (!vpd_rd_req) break;
    end
    checks++;
    if (n != TO) begin errors++; $display("FAIL timeout_cycles got=%0d required=%0d", n, TO); end
    checks++;
    if ({load_done, load_error} !== 3'b111) begin
      errors++; $display("FAIL timeout_status got=%b required=111", {load_done, load_error});
    end
    force_data = $urandom;
    force_ack = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    force_ack = 1'b0;
    checks++;
    if ({vpd_rd_req, load_done, load_error} !== 4'b0111 || hs_cnt - hs0 != 2 ||
        outs !== {DID, DVID, DDSN, DID, DVID}) begin
      errors++; $display("FAIL timeout_late_ack got=%b/%0d/%h required=0111/2/defaults",
                         {vpd_rd_req, load_done, load_error}, hs_cnt - hs0, outs);
    end
    cur = dflt;
  endtask

  task automatic test_reload();
    int hs0, u0, cyc, ch, bad;
    exp_t e;
    make_valid(16'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
    set_dly(0, 0);
    e = model(dflt);
    reset_and_release();
    run_load(-1, cyc, ch);
    checks++;
    if (load_error !== 2'b00 || outs !== {e.id, e.vid, e.dsn, e.id, e.vid}) begin
      errors++; $display("FAIL reload_first got=%b/%h required=00/%h", load_error, outs,
                         {e.id, e.vid, e.dsn, e.id, e.vid});
    end
    make_valid(16'h0001, 16'($urandom), {32'($urandom), 32'($urandom)});
    set_dly(3, 3);
    cur = e;
    e = model(cur);
    hs0 = hs_cnt;
    u0 = unstable;
    pulse_reload();
    #1;
    checks++;
    if ({load_done, load_error} !== 3'b000) begin
      errors++; $display("FAIL reload_clear got=%b required=000", {load_done, load_error});
    end
    run_load(4, cyc, ch);
    checks++;
    if (ch != 0 || cyc != exp_cycles(e)) begin
      errors++; $display("FAIL reload_hold early_changes=%0d cyc=%0d required=0/%0d", ch, cyc, exp_cycles(e));
    end
    checks++;
    if (load_error !== 2'b00 || outs !== {e.id, e.vid, e.dsn, e.id, e.vid}) begin
      errors++; $display("FAIL reload_commit got=%b/%h required=00/%h", load_error, outs,
                         {e.id, e.vid, e.dsn, e.id, e.vid});
    end
    bad = 0;
    for (int i = 0; i < 5; i++) if (hs_addr[hs0 + i] !== 8'(i)) bad++;
    checks++;
    if (hs_cnt - hs0 != 5 || bad != 0 || unstable != u0) begin
      errors++; $display("FAIL reload_addr reads=%0d bad=%0d unstable=%0d required=5/0/0",
                         hs_cnt - hs0, bad, unstable - u0);
    end
    cur = e;
  endtask

  task automatic test_reset_mid();
    int hs0, cyc, ch, bad;
    exp_t e;
    make_valid(16'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
    set_dly(0, 0);
    hs0 = hs_cnt;
    pulse_reload();
    for (int k = 0; k < 50; k++) begin
      @(posedge clock);
      #1;
      if (hs_cnt == hs0 + 3) break;
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({vpd_rd_req, vpd_rd_addr, load_done, load_error} !== 12'h000 ||
        outs !== {DID, DVID, DDSN, DID, DVID}) begin
      errors++; $display("FAIL midreset_values got=%h/%h required=000/defaults",
                         {vpd_rd_req, vpd_rd_addr, load_done, load_error}, outs);
    end
    e = model(dflt);
    hs0 = hs_cnt;
    @(negedge clock);
    #2 reset_n = 1'b1;
    run_load(-1, cyc, ch);
    bad = 0;
    for (int i = 0; i < 5; i++) if (hs_addr[hs0 + i] !== 8'(i)) bad++;
    checks++;
    if (load_error !== 2'b00 || cyc != 7 || bad != 0 || outs !== {e.id, e.vid, e.dsn, e.id, e.vid}) begin
      errors++; $display("FAIL midreset_reload got=%b/%0d/%0d/%h required=00/7/0/%h", load_error, cyc, bad,
                         outs, {e.id, e.vid, e.dsn, e.id, e.vid});
    end
    cur = e;
  endtask

  task automatic test_random();
    int hs0, cyc, ch, kind;
    exp_t e;
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(2, 0);
      make_valid(16'($urandom), 16'($urandom), {32'($urandom), 32'($urandom)});
      if (kind == 1) img[0] = MAGIC ^ (32'($urandom) | 32'h1);
      if (kind == 2) img[4] = img[4] + 32'($urandom_range(1000, 1));
      set_dly(0, 4);
      e = model(cur);
      hs0 = hs_cnt;
      pulse_reload();
      run_load(-1, cyc, ch);
      checks++;
      if (load_error !== e.err || hs_cnt - hs0 != e.nreads || cyc != exp_cycles(e)) begin
        errors++; $display("FAIL rand_status it=%0d got=%b/%0d/%0d required=%b/%0d/%0d", it, load_error,
                           hs_cnt - hs0, cyc, e.err, e.nreads, exp_cycles(e));
      end
      checks++;
      if (outs !== {e.id, e.vid, e.dsn, e.id, e.vid} || ch != 0) begin
        errors++; $display("FAIL rand_outputs it=%0d got=%h early=%0d required=%h", it, outs, ch,
                           {e.id, e.vid, e.dsn, e.id, e.vid});
      end
      cur = e;
    end
  endtask

  initial begin
    dflt = '{err: 2'b00, id: DID, vid: DVID, dsn: DDSN, nreads: 0};
    cur = dflt;
    test_reset();
    test_valid();
    test_bad_magic();
    test_bad_checksum();
    test_timeout();
    test_reload();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
